// File: rtl/cache_writeback_ctrl.sv
// cache_writeback_ctrl: miss engine that writes back a dirty victim, fetches the new line and fills the cache
module cache_writeback_ctrl #(
   parameter int TAG_W  = 9,
   parameter int SET_W  = 3,
   parameter int LINE_W = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              miss_req,
   input  logic [SET_W-1:0]  miss_set,
   input  logic [TAG_W-1:0]  miss_tag,
   input  logic              victim_way,
   input  logic              victim_dirty,
   input  logic [TAG_W-1:0]  victim_tag,
   input  logic [LINE_W-1:0] victim_line,
   input  logic              pmem_resp,
   input  logic [LINE_W-1:0] pmem_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [15:0]       pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   output logic              fill_load,
   output logic [SET_W-1:0]  fill_set,
   output logic              fill_way,
   output logic [TAG_W-1:0]  fill_tag,
   output logic [LINE_W-1:0] fill_line,
   output logic              dirty_clear,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  miss_count,
   output logic [CNT_W-1:0]  wb_count
);
   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;
   state_t state, state_nx;
   logic [SET_W-1:0]  set_q;
   logic [TAG_W-1:0]  tag_q, vtag_q;
   logic              way_q;
   logic [LINE_W-1:0] line_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = miss_req ? (victim_dirty ? WRITEBACK : FETCH) : IDLE;
         WRITEBACK: state_nx = pmem_resp ? FETCH : WRITEBACK;
         FETCH:     state_nx = pmem_resp ? FILL : FETCH;
         default:   state_nx = IDLE;
      endcase
   end
   // line_q holds the victim line until writeback completes, then the fetched line
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         set_q      <= '0;
         tag_q      <= '0;
         vtag_q     <= '0;
         way_q      <= 1'b0;
         line_q     <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (state == IDLE && miss_req) begin
            set_q      <= miss_set;
            tag_q      <= miss_tag;
            vtag_q     <= victim_tag;
            way_q      <= victim_way;
            line_q     <= victim_line;
            miss_count <= miss_count + CNT_W'(miss_count != '1);
         end
         if (state == WRITEBACK && pmem_resp) wb_count <= wb_count + CNT_W'(wb_count != '1);
         if (state == FETCH && pmem_resp) line_q <= pmem_rdata;
      end
   always_comb begin
      pmem_write   = state == WRITEBACK;
      pmem_read    = state == FETCH;
      fill_load    = state == FILL;
      dirty_clear  = state == FILL;
      done         = state == FILL;
      busy         = state != IDLE;
      pmem_address = {(state == WRITEBACK) ? vtag_q : tag_q, set_q, 4'b0};
      pmem_wdata   = line_q;
      fill_set     = set_q;
      fill_way     = way_q;
      fill_tag     = tag_q;
      fill_line    = line_q;
   end
endmodule

// File: tb/tb_cache_writeback_ctrl.sv
// tb_cache_writeback_ctrl: directed and randomized misses against a transaction-level memory/cache model
module tb_cache_writeback_ctrl;
   logic         clk, reset_n, miss_req, victim_way, victim_dirty, pmem_resp;
   logic [2:0]   miss_set;
   logic [8:0]   miss_tag, victim_tag;
   logic [127:0] victim_line, pmem_rdata;
   logic         pmem_read, pmem_write, fill_load, fill_way, dirty_clear, busy, done;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata, fill_line;
   logic [2:0]   fill_set;
   logic [8:0]   fill_tag;
   logic [15:0]  miss_count, wb_count;
   logic         r4, w4, fl4, fw4, dc4, b4, d4;
   logic [15:0]  a4;
   logic [127:0] wd4, fln4;
   logic [2:0]   fs4;
   logic [8:0]   ft4;
   logic [3:0]   mc4, wc4;
   int n_chk = 0, n_fail = 0, mc = 0, wc = 0;

   cache_writeback_ctrl dut (
      .clk(clk), .reset_n(reset_n), .miss_req(miss_req), .miss_set(miss_set), .miss_tag(miss_tag),
      .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
      .victim_line(victim_line), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .fill_load(fill_load), .fill_set(fill_set), .fill_way(fill_way),
      .fill_tag(fill_tag), .fill_line(fill_line), .dirty_clear(dirty_clear), .busy(busy),
      .done(done), .miss_count(miss_count), .wb_count(wb_count));

   cache_writeback_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .miss_req(miss_req), .miss_set(miss_set), .miss_tag(miss_tag),
      .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
      .victim_line(victim_line), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .pmem_read(r4), .pmem_write(w4), .pmem_address(a4), .pmem_wdata(wd4), .fill_load(fl4),
      .fill_set(fs4), .fill_way(fw4), .fill_tag(ft4), .fill_line(fln4), .dirty_clear(dc4),
      .busy(b4), .done(d4), .miss_count(mc4), .wb_count(wc4));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] line_addr(input logic [8:0] t, input logic [2:0] s);
      return 16'(t) * 16'd128 + 16'(s) * 16'd16;
   endfunction

   task automatic chk_counts();
      chk("miss_count", 128'(miss_count), 128'(mc > 65535 ? 65535 : mc));
      chk("wb_count", 128'(wb_count), 128'(wc > 65535 ? 65535 : wc));
      chk("miss_count_sat4", 128'(mc4), 128'(mc > 15 ? 15 : mc));
      chk("wb_count_sat4", 128'(wc4), 128'(wc > 15 ? 15 : wc));
   endtask

   task automatic rnd_line(output logic [127:0] l);
      l = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // one complete miss transaction; memory answers after lat request cycles
   task automatic miss(input logic [2:0] s, input logic [8:0] t, input logic w, input logic dirty,
                       input logic [8:0] vt, input logic [127:0] vl, input int lat, input logic scramble);
      logic [127:0] nl, junk;
      rnd_line(nl);
      chk("idle_busy", 128'(busy), 0);
      chk("idle_done", 128'(done), 0);
      chk("idle_rw", 128'({pmem_read, pmem_write}), 0);
      miss_req = 1; miss_set = s; miss_tag = t; victim_way = w; victim_dirty = dirty;
      victim_tag = vt; victim_line = vl; pmem_resp = 1'($urandom_range(0, 1));
      @(negedge clk);
      pmem_resp = 0;
      mc++;
      if (scramble) begin
         miss_set = 3'($urandom); miss_tag = 9'($urandom); victim_way = ~w;
         victim_dirty = ~dirty; victim_tag = 9'($urandom); rnd_line(junk); victim_line = junk;
      end
      if (dirty) begin
         for (int c = 1; c <= lat; c++) begin
            chk("wb_rw", 128'({pmem_read, pmem_write}), 128'(2'b01));
            chk("wb_addr", 128'(pmem_address), 128'(line_addr(vt, s)));
            chk("wb_wdata", pmem_wdata, vl);
            chk("wb_done", 128'({done, fill_load}), 0);
            pmem_resp = (c == lat);
            @(negedge clk);
            pmem_resp = 0;
         end
         wc++;
      end
      for (int c = 1; c <= lat; c++) begin
         chk("fetch_rw", 128'({pmem_read, pmem_write}), 128'(2'b10));
         chk("fetch_addr", 128'(pmem_address), 128'(line_addr(t, s)));
         chk("fetch_busy", 128'({busy, done}), 128'(2'b10));
         pmem_resp = (c == lat);
         rnd_line(junk);
         pmem_rdata = (c == lat) ? nl : junk;
         @(negedge clk);
         pmem_resp = 0;
         rnd_line(junk);
         pmem_rdata = junk;
      end
      chk("fill_strobes", 128'({fill_load, dirty_clear, done, busy}), 128'(4'hF));
      chk("fill_rw", 128'({pmem_read, pmem_write}), 0);
      chk("fill_set", 128'(fill_set), 128'(s));
      chk("fill_way", 128'(fill_way), 128'(w));
      chk("fill_tag", 128'(fill_tag), 128'(t));
      chk("fill_line", fill_line, nl);
      chk_counts();
      miss_req = 0;
      pmem_resp = 1'($urandom_range(0, 1));
      @(negedge clk);
      pmem_resp = 0;
      chk("post_fill", 128'({fill_load, dirty_clear, done}), 0);
   endtask

   initial begin
      logic [127:0] l;
      reset_n = 0; miss_req = 0; miss_set = 0; miss_tag = 0; victim_way = 0; victim_dirty = 0;
      victim_tag = 0; victim_line = 0; pmem_resp = 0; pmem_rdata = 0;
      repeat (2) @(negedge clk);
      chk("rst_strobes", 128'({pmem_read, pmem_write, fill_load, dirty_clear, busy, done}), 0);
      chk("rst_addr", 128'(pmem_address), 0);
      chk("rst_fill", 128'({fill_set, fill_way, fill_tag}), 0);
      chk_counts();
      reset_n = 1;
      @(negedge clk);
      rnd_line(l);
      miss(3'd3, 9'h055, 1'b0, 1'b0, 9'h0AA, l, 3, 1'b0);
      rnd_line(l);
      miss(3'd5, 9'h001, 1'b1, 1'b1, 9'h1FF, l, 2, 1'b0);
      rnd_line(l);
      miss(3'd7, 9'h123, 1'b0, 1'b1, 9'h0F0, l, 1, 1'b1);
      rnd_line(l);
      miss(3'd0, 9'h1AB, 1'b1, 1'b0, 9'h002, l, 2, 1'b1);
      // abort during writeback: async reset must clear everything without a fill
      rnd_line(l);
      miss_req = 1; miss_set = 3'd2; miss_tag = 9'h0C3; victim_way = 1; victim_dirty = 1;
      victim_tag = 9'h155; victim_line = l;
      @(negedge clk);
      chk("abort_wb", 128'(pmem_write), 1);
      #2 reset_n = 0;
      #1;
      chk("abort_rw", 128'({pmem_read, pmem_write, busy}), 0);
      mc = 0; wc = 0;
      chk_counts();
      miss_req = 0;
      pmem_resp = 1;
      @(negedge clk);
      pmem_resp = 0;
      chk("abort_nofill", 128'({fill_load, dirty_clear, done, busy}), 0);
      reset_n = 1;
      @(negedge clk);
      rnd_line(l);
      miss(3'd2, 9'h0C3, 1'b1, 1'b1, 9'h155, l, 2, 1'b0);
      for (int i = 0; i < 20; i++) begin
         rnd_line(l);
         miss(3'($urandom), 9'($urandom), 1'($urandom), 1'b1, 9'($urandom), l,
              int'($urandom_range(1, 4)), 1'($urandom));
      end
      for (int i = 0; i < 6; i++) begin
         rnd_line(l);
         miss(3'($urandom), 9'($urandom), 1'($urandom), 1'($urandom), 9'($urandom), l,
              int'($urandom_range(1, 3)), 1'($urandom));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
